pipe_stall_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage integer pipeline. It owns every pipeline-register write enable and flush. It merges four stall sources:
- load-use hazard detection;
- taken-branch redirect;
- multi-cycle mul/div occupancy of EX;
- data-memory wait states.

It sits beside the pipeline registers in the core top level and replaces ad-hoc per-stage stall wiring.

---
 rtl/pipe_ctrl_pkg.sv | 29 ++
 rtl/load_use_cmp.sv | 15 +
 rtl/pipe_stall_ctrl.sv | 177 +++++++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline stall/flush sequencer
package pipe_ctrl_pkg;

  localparam int REG_IDX_W = 5;
  localparam int STATE_W   = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_RUN      = 2'd0,
    ST_MD_BUSY  = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_e;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic id_ex_write;
    logic ex_mem_write;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
  } ctrl_t;

  localparam ctrl_t CTRL_RESET    = 7'b0000_000;
  localparam ctrl_t CTRL_RUN      = 7'b1111_000;
  localparam ctrl_t CTRL_FREEZE   = 7'b0000_000;
  // EX is occupied: hold the front end and feed bubbles into MEM.
  localparam ctrl_t CTRL_MD_STALL = 7'b0001_001;

endpackage

// File: rtl/load_use_cmp.sv
// rtl/load_use_cmp.sv - load-use hazard comparator between the load in EX and the sources in ID
module load_use_cmp
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_IDX_W-1:0] rs1_i,
  input  logic [REG_IDX_W-1:0] rs2_i,
  input  logic [REG_IDX_W-1:0] rd_i,
  input  logic                 memread_i,
  output logic                 hazard_o
);

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign hazard_o = memread_i && (rd_i != '0) && ((rd_i == rs1_i) || (rd_i == rs2_i));

endmodule

// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - central stall/flush sequencer for the 5-stage integer pipeline
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_MAX_CYC = 64,
  parameter int CNT_W      = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [REG_IDX_W-1:0] if_id_rs1_i,
  input  logic [REG_IDX_W-1:0] if_id_rs2_i,
  input  logic [REG_IDX_W-1:0] id_ex_rd_i,
  input  logic                 id_ex_memread_i,
  input  logic                 branch_taken_i,
  input  logic                 md_start_i,
  input  logic                 md_done_i,
  input  logic                 dmem_req_i,
  input  logic                 dmem_ready_i,
  input  logic                 stall_cnt_clr_i,
  output logic                 pc_write_o,
  output logic                 if_id_write_o,
  output logic                 id_ex_write_o,
  output logic                 ex_mem_write_o,
  output logic                 if_id_flush_o,
  output logic                 id_ex_flush_o,
  output logic                 ex_mem_flush_o,
  output logic                 md_timeout_o,
  output logic [STATE_W-1:0]   state_o,
  output logic [CNT_W-1:0]     stall_cnt_o
);

  localparam int WD_W = $clog2(MD_MAX_CYC + 1);

  state_e           state_q, state_d;
  logic             ret_md_q, ret_md_d;
  logic             done_pend_q, done_pend_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic  freeze;
  logic  lu_haz;
  logic  timeout;
  logic  run_start;
  ctrl_t run_ctrl;
  ctrl_t ctrl;
  ctrl_t ctrl_out;

  load_use_cmp u_load_use_cmp (
    .rs1_i     (if_id_rs1_i),
    .rs2_i     (if_id_rs2_i),
    .rd_i      (id_ex_rd_i),
    .memread_i (id_ex_memread_i),
    .hazard_o  (lu_haz)
  );

  assign freeze = dmem_req_i & ~dmem_ready_i;

  always_comb begin
    run_ctrl  = CTRL_RUN;
    run_start = 1'b0;
    if (branch_taken_i) begin
      run_ctrl.if_id_flush = 1'b1;
      run_ctrl.id_ex_flush = 1'b1;
    end else if (md_start_i) begin
      run_ctrl  = CTRL_MD_STALL;
      run_start = 1'b1;
    end else if (lu_haz) begin
      run_ctrl.pc_write    = 1'b0;
      run_ctrl.if_id_write = 1'b0;
      run_ctrl.id_ex_flush = 1'b1;
    end
  end

  always_comb begin
    ctrl        = CTRL_RUN;
    state_d     = state_q;
    ret_md_d    = ret_md_q;
    done_pend_d = done_pend_q;
    wd_d        = wd_q;
    timeout     = 1'b0;
    if (freeze) begin
      ctrl = CTRL_FREEZE;
      if (state_q != ST_MEM_WAIT) begin
        ret_md_d = (state_q == ST_MD_BUSY);
        state_d  = ST_MEM_WAIT;
      end
      // The unit pulses done only once, so remember it across the freeze.
      if (md_done_i && ((state_q == ST_MD_BUSY) || ((state_q == ST_MEM_WAIT) && ret_md_q))) begin
        done_pend_d = 1'b1;
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          ctrl = run_ctrl;
          if (run_start) begin
            state_d = ST_MD_BUSY;
            wd_d    = WD_W'(1);
          end
        end
        ST_MD_BUSY: begin
          if (md_done_i || done_pend_q) begin
            ctrl        = CTRL_RUN;
            state_d     = ST_RUN;
            done_pend_d = 1'b0;
            wd_d        = '0;
          end else if (wd_q == WD_W'(MD_MAX_CYC)) begin
            ctrl        = CTRL_RUN;
            timeout     = 1'b1;
            state_d     = ST_RUN;
            wd_d        = '0;
          end else begin
            ctrl = CTRL_MD_STALL;
            wd_d = wd_q + WD_W'(1);
          end
        end
        ST_MEM_WAIT: begin
          // Release cycle: resume the interrupted context; a pending done is taken next cycle.
          if (ret_md_q) begin
            ctrl    = CTRL_MD_STALL;
            state_d = ST_MD_BUSY;
            if (md_done_i) begin
              done_pend_d = 1'b1;
            end
          end else begin
            ctrl    = run_ctrl;
            state_d = ST_RUN;
            if (run_start) begin
              state_d = ST_MD_BUSY;
              wd_d    = WD_W'(1);
            end
          end
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall_cnt_clr_i) begin
      cnt_d = '0;
    end else if (!ctrl.pc_write && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_RUN;
      ret_md_q    <= 1'b0;
      done_pend_q <= 1'b0;
      wd_q        <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      ret_md_q    <= ret_md_d;
      done_pend_q <= done_pend_d;
      wd_q        <= wd_d;
      cnt_q       <= cnt_d;
    end
  end

  assign ctrl_out       = rst_n_i ? ctrl : CTRL_RESET;
  assign pc_write_o     = ctrl_out.pc_write;
  assign if_id_write_o  = ctrl_out.if_id_write;
  assign id_ex_write_o  = ctrl_out.id_ex_write;
  assign ex_mem_write_o = ctrl_out.ex_mem_write;
  assign if_id_flush_o  = ctrl_out.if_id_flush;
  assign id_ex_flush_o  = ctrl_out.id_ex_flush;
  assign ex_mem_flush_o = ctrl_out.ex_mem_flush;
  assign md_timeout_o   = timeout & rst_n_i;
  assign state_o        = state_q;
  assign stall_cnt_o    = cnt_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - directed self-checking bench for pipe_stall_ctrl
module tb_pipe_stall_ctrl;

  localparam logic [6:0] C_RUN    = 7'b1111_000;
  localparam logic [6:0] C_LU     = 7'b0011_010;
  localparam logic [6:0] C_BRANCH = 7'b1111_110;
  localparam logic [6:0] C_MD     = 7'b0001_001;
  localparam logic [6:0] C_FREEZE = 7'b0000_000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs1, rs2, rd;
  logic       memread, branch, md_start, md_done, dmem_req, dmem_ready, clr;
  logic       pc_w, ifid_w, idex_w, exmem_w, ifid_f, idex_f, exmem_f, timeout;
  logic [1:0] state;
  logic [7:0] cnt;
  logic [6:0] ctl;

  int checks = 0;
  int errors = 0;

  assign ctl = {pc_w, ifid_w, idex_w, exmem_w, ifid_f, idex_f, exmem_f};

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.MD_MAX_CYC(8), .CNT_W(8)) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .if_id_rs1_i     (rs1),
    .if_id_rs2_i     (rs2),
    .id_ex_rd_i      (rd),
    .id_ex_memread_i (memread),
    .branch_taken_i  (branch),
    .md_start_i      (md_start),
    .md_done_i       (md_done),
    .dmem_req_i      (dmem_req),
    .dmem_ready_i    (dmem_ready),
    .stall_cnt_clr_i (clr),
    .pc_write_o      (pc_w),
    .if_id_write_o   (ifid_w),
    .id_ex_write_o   (idex_w),
    .ex_mem_write_o  (exmem_w),
    .if_id_flush_o   (ifid_f),
    .id_ex_flush_o   (idex_f),
    .ex_mem_flush_o  (exmem_f),
    .md_timeout_o    (timeout),
    .state_o         (state),
    .stall_cnt_o     (cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rs1 = 5'd1; rs2 = 5'd2; rd = 5'd3; memread = 1'b0; branch = 1'b0;
    md_start = 1'b0; md_done = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b1; clr = 1'b0;
  endtask

  task automatic clear_cnt();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ctl !== 7'b0) begin errors++; $display("FAIL reset_ctl: got %b expected %b", ctl, 7'b0); end
    checks++; if ({timeout, state, cnt} !== 11'b0) begin errors++; $display("FAIL reset_state: got t=%b s=%0d c=%0d expected all 0", timeout, state, cnt); end
    step();
    rst_n = 1'b1;
    #1;
    checks++; if (ctl !== C_RUN) begin errors++; $display("FAIL run_default: got %b expected %b", ctl, C_RUN); end
  endtask

  task automatic test_load_use();
    rd = 5'd5; rs2 = 5'd5; memread = 1'b1;
    #1;
    checks++; if (ctl !== C_LU) begin errors++; $display("FAIL lu_rs2_ctl: got %b expected %b", ctl, C_LU); end
    step(); idle(); #1;
    checks++; if (cnt !== 8'd1) begin errors++; $display("FAIL lu_cnt: got %0d expected 1", cnt); end
    checks++; if (ctl !== C_RUN) begin errors++; $display("FAIL lu_one_bubble: got %b expected %b", ctl, C_RUN); end
    rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; memread = 1'b1;
    #1;
    checks++; if (ctl !== C_RUN) begin errors++; $display("FAIL lu_x0: got %b expected %b", ctl, C_RUN); end
    step(); idle();
    rd = 5'd7; rs1 = 5'd7; memread = 1'b1;
    #1;
    checks++; if (ctl !== C_LU) begin errors++; $display("FAIL lu_rs1_ctl: got %b expected %b", ctl, C_LU); end
    step(); idle();
    rd = 5'd7; rs1 = 5'd7; memread = 1'b0;
    #1;
    checks++; if ({ctl, cnt} !== {C_RUN, 8'd2}) begin errors++; $display("FAIL lu_no_load: got %b/%0d expected %b/2", ctl, cnt, C_RUN); end
    step(); idle();
  endtask

  task automatic test_branch();
    branch = 1'b1; memread = 1'b1; rd = 5'd3; rs1 = 5'd3;
    #1;
    checks++; if (ctl !== C_BRANCH) begin errors++; $display("FAIL br_over_lu: got %b expected %b", ctl, C_BRANCH); end
    step(); idle();
    branch = 1'b1; md_start = 1'b1;
    #1;
    checks++; if ({ctl, cnt} !== {C_BRANCH, 8'd2}) begin errors++; $display("FAIL br_over_md: got %b/%0d expected %b/2", ctl, cnt, C_BRANCH); end
    step(); idle(); #1;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL br_state: got %0d expected 0", state); end
  endtask

  task automatic test_mul_div();
    clear_cnt();
    md_start = 1'b1; md_done = 1'b1;
    #1;
    checks++; if (ctl !== C_MD) begin errors++; $display("FAIL md_start_ctl: got %b expected %b", ctl, C_MD); end
    step(); idle();
    for (int k = 1; k <= 4; k++) begin
      #1;
      checks++; if ({state, ctl} !== {2'd1, C_MD}) begin errors++; $display("FAIL md_busy_%0d: got s=%0d %b expected s=1 %b", k, state, ctl, C_MD); end
      step();
    end
    md_done = 1'b1;
    #1;
    checks++; if ({state, ctl} !== {2'd1, C_RUN}) begin errors++; $display("FAIL md_done_ctl: got s=%0d %b expected s=1 %b", state, ctl, C_RUN); end
    step(); idle(); #1;
    checks++; if ({state, cnt} !== {2'd0, 8'd5}) begin errors++; $display("FAIL md_after: got s=%0d c=%0d expected s=0 c=5", state, cnt); end
  endtask

  task automatic test_timeout();
    clear_cnt();
    md_start = 1'b1;
    step(); idle();
    for (int k = 1; k <= 7; k++) begin
      #1;
      checks++; if ({timeout, ctl} !== {1'b0, C_MD}) begin errors++; $display("FAIL wd_busy_%0d: got t=%b %b expected t=0 %b", k, timeout, ctl, C_MD); end
      step();
    end
    #1;
    checks++; if ({timeout, state, ctl} !== {1'b1, 2'd1, C_RUN}) begin errors++; $display("FAIL wd_expire: got t=%b s=%0d %b expected t=1 s=1 %b", timeout, state, ctl, C_RUN); end
    step(); #1;
    checks++; if ({timeout, state, cnt} !== {1'b0, 2'd0, 8'd8}) begin errors++; $display("FAIL wd_after: got t=%b s=%0d c=%0d expected t=0 s=0 c=8", timeout, state, cnt); end
  endtask

  task automatic test_mem_wait();
    clear_cnt();
    md_start = 1'b1;
    step(); idle(); #1;
    checks++; if (ctl !== C_MD) begin errors++; $display("FAIL mw_busy: got %b expected %b", ctl, C_MD); end
    step();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    #1;
    checks++; if ({state, ctl} !== {2'd1, C_FREEZE}) begin errors++; $display("FAIL mw_c1: got s=%0d %b expected s=1 %b", state, ctl, C_FREEZE); end
    step();
    md_done = 1'b1;
    #1;
    checks++; if ({state, ctl} !== {2'd2, C_FREEZE}) begin errors++; $display("FAIL mw_c2: got s=%0d %b expected s=2 %b", state, ctl, C_FREEZE); end
    step();
    md_done = 1'b0;
    #1;
    checks++; if ({state, ctl} !== {2'd2, C_FREEZE}) begin errors++; $display("FAIL mw_c3: got s=%0d %b expected s=2 %b", state, ctl, C_FREEZE); end
    step();
    dmem_req = 1'b0; dmem_ready = 1'b1;
    #1;
    checks++; if ({state, ctl} !== {2'd2, C_MD}) begin errors++; $display("FAIL mw_release: got s=%0d %b expected s=2 %b", state, ctl, C_MD); end
    step(); #1;
    checks++; if ({state, ctl} !== {2'd1, C_RUN}) begin errors++; $display("FAIL mw_pending_done: got s=%0d %b expected s=1 %b", state, ctl, C_RUN); end
    step(); #1;
    checks++; if ({state, cnt} !== {2'd0, 8'd6}) begin errors++; $display("FAIL mw_after: got s=%0d c=%0d expected s=0 c=6", state, cnt); end
  endtask

  task automatic test_freeze_branch();
    dmem_req = 1'b1; dmem_ready = 1'b0; branch = 1'b1;
    #1;
    checks++; if (ctl !== C_FREEZE) begin errors++; $display("FAIL fz_over_br: got %b expected %b", ctl, C_FREEZE); end
    step();
    dmem_ready = 1'b1;
    #1;
    checks++; if ({state, ctl} !== {2'd2, C_BRANCH}) begin errors++; $display("FAIL fz_br_release: got s=%0d %b expected s=2 %b", state, ctl, C_BRANCH); end
    step(); idle(); #1;
    checks++; if ({state, ctl} !== {2'd0, C_RUN}) begin errors++; $display("FAIL fz_br_after: got s=%0d %b expected s=0 %b", state, ctl, C_RUN); end
  endtask

  task automatic test_reset_mid();
    md_start = 1'b1;
    step(); idle();
    dmem_req = 1'b1; dmem_ready = 1'b0; md_done = 1'b1;
    step();
    md_done = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if ({ctl, state, cnt} !== {7'b0, 2'd0, 8'd0}) begin errors++; $display("FAIL rst_mid: got %b s=%0d c=%0d expected 0 s=0 c=0", ctl, state, cnt); end
    step();
    rst_n = 1'b1; idle();
    #1;
    checks++; if ({state, ctl} !== {2'd0, C_RUN}) begin errors++; $display("FAIL rst_release: got s=%0d %b expected s=0 %b", state, ctl, C_RUN); end
    md_start = 1'b1;
    step(); idle(); #1;
    checks++; if ({state, ctl} !== {2'd1, C_MD}) begin errors++; $display("FAIL rst_no_pending: got s=%0d %b expected s=1 %b", state, ctl, C_MD); end
    md_done = 1'b1;
    step(); idle();
  endtask

  task automatic test_clr_and_saturate();
    rd = 5'd5; rs2 = 5'd5; memread = 1'b1; clr = 1'b1;
    step(); clr = 1'b0; #1;
    checks++; if (cnt !== 8'd0) begin errors++; $display("FAIL clr_wins: got %0d expected 0", cnt); end
    repeat (260) step();
    checks++; if (cnt !== 8'd255) begin errors++; $display("FAIL cnt_saturate: got %0d expected 255", cnt); end
    idle();
    step();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_mul_div();
    test_timeout();
    test_mem_wait();
    test_freeze_branch();
    test_reset_mid();
    test_clr_and_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
